led_matrix_scanner: RTL

Row-scanning driver for the 16x16 red/green LED board. It takes the two 16x16 frame arrays from the pattern/game logic and snapshots them once per frame so the display never tears. It then time-multiplexes them one row at a time onto the board's row-enable and column-drive lines, with a blanking gap between rows. A frame-start pulse lets upstream logic advance its animation in lockstep with the scan.

---
 rtl/led_matrix_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner -- row-scanning driver for the 16x16 red/green LED board.
//
// Snapshots both colour frames once per frame (LOAD), then walks rows 0..15,
// each row preceded by an all-off blanking gap (BLANK) and driven for DWELL
// cycles (DRIVE). A one-cycle FrameStart pulse marks each snapshot.
//
// Optional feature, macro LED_SCAN_DIM_EN: adds the 2-bit Brightness port,
// sampled at LOAD and held for the frame; column drives are gated off once the
// elapsed dwell count reaches (Brightness+1)*DWELL/4. RowEn is unaffected.
// Without the macro the columns are driven for the full dwell (Brightness=3).
//
// All outputs are registered: each edge produces the outputs that belong to
// the state the FSM occupied just before that edge, so the visible sequence is
// LOAD(1), then {BLANK x BLANK, DRIVE x DWELL} for each of the 16 rows.

module led_matrix_scanner #(
   parameter int DWELL = 2048,  // >= 4, multiple of 4
   parameter int BLANK = 16     // >= 1, < DWELL
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [15:0][15:0]   RedPixels,
   input  logic [15:0][15:0]   GrnPixels,
`ifdef LED_SCAN_DIM_EN
   input  logic [1:0]          Brightness,
`endif
   output logic [15:0]         RowEn,
   output logic [15:0]         RedDrv,
   output logic [15:0]         GrnDrv,
   output logic                FrameStart
);

   // Shared BLANK/DRIVE down-counter width; BLANK < DWELL keeps both loads in range.
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_BLANK,
      S_DRIVE
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       row_q, row_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [15:0][15:0] red_buf_q, red_buf_d;
   logic [15:0][15:0] grn_buf_q, grn_buf_d;
   logic [15:0]      row_en_q, row_en_d;
   logic [15:0]      red_drv_q, red_drv_d;
   logic [15:0]      grn_drv_q, grn_drv_d;
   logic             frame_start_q, frame_start_d;
   logic             col_on;

`ifdef LED_SCAN_DIM_EN
   logic [1:0]       bright_q, bright_d;
   logic [31:0]      elapsed_w;
   logic [31:0]      on_limit;

   // Columns stay on while the elapsed dwell count is below the brightness window.
   always_comb begin
      elapsed_w = 32'(DWELL_LAST - cnt_q);
      on_limit  = (32'(bright_q) + 32'd1) * 32'(DWELL / 4);
      col_on    = (elapsed_w < on_limit);
   end
`else
   assign col_on = 1'b1;
`endif

   // Next-state, counter, snapshot and registered-output logic for the scan FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one
      // unassigned; an unassigned path in always_comb would infer a latch.
      state_d       = state_q;
      row_d         = row_q;
      cnt_d         = cnt_q;
      red_buf_d     = red_buf_q;
      grn_buf_d     = grn_buf_q;
      row_en_d      = '0;
      red_drv_d     = '0;
      grn_drv_d     = '0;
      frame_start_d = 1'b0;
`ifdef LED_SCAN_DIM_EN
      bright_d      = bright_q;
`endif

      case (state_q)
         S_LOAD: begin
            red_buf_d     = RedPixels;
            grn_buf_d     = GrnPixels;
`ifdef LED_SCAN_DIM_EN
            bright_d      = Brightness;
`endif
            frame_start_d = 1'b1;
            row_d         = 4'd0;
            cnt_d         = BLANK_LAST;
            state_d       = S_BLANK;
         end

         S_BLANK: begin
            if (cnt_q == '0) begin
               cnt_d   = DWELL_LAST;
               state_d = S_DRIVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_DRIVE: begin
            row_en_d = 16'h0001 << row_q;
            if (col_on) begin
               red_drv_d = red_buf_q[row_q];
               grn_drv_d = grn_buf_q[row_q];
            end
            if (cnt_q == '0) begin
               if (row_q == 4'd15) begin
                  state_d = S_LOAD;
               end else begin
                  row_d   = row_q + 4'd1;
                  cnt_d   = BLANK_LAST;
                  state_d = S_BLANK;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // State, frame buffer and output registers with synchronous active-high reset.
   always_ff @(posedge CLK) begin
      // NOTE: the frame buffer is cleared on reset so a restart never shows stale
      // pixels; it is small enough that a reset on every bit costs nothing here.
      if (RST) begin
         // NOTE: non-blocking assignments throughout so every register samples
         // the pre-edge values regardless of statement order.
         state_q       <= S_LOAD;
         row_q         <= 4'd0;
         cnt_q         <= '0;
         red_buf_q     <= '0;
         grn_buf_q     <= '0;
         row_en_q      <= '0;
         red_drv_q     <= '0;
         grn_drv_q     <= '0;
         frame_start_q <= 1'b0;
`ifdef LED_SCAN_DIM_EN
         bright_q      <= 2'd0;
`endif
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         cnt_q         <= cnt_d;
         red_buf_q     <= red_buf_d;
         grn_buf_q     <= grn_buf_d;
         row_en_q      <= row_en_d;
         red_drv_q     <= red_drv_d;
         grn_drv_q     <= grn_drv_d;
         frame_start_q <= frame_start_d;
`ifdef LED_SCAN_DIM_EN
         bright_q      <= bright_d;
`endif
      end
   end

   assign RowEn      = row_en_q;
   assign RedDrv     = red_drv_q;
   assign GrnDrv     = grn_drv_q;
   assign FrameStart = frame_start_q;

endmodule
